// File: rtl/sr_request_conditioner.sv
// Conditions raw asynchronous set/clear requests into debounced, mutually exclusive
// S/R pulses for a downstream sr_flipflop, with a fixed conflict policy and counter.
module sr_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int PRIORITY        = 0,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_in,
  input  logic             clr_in,
  input  logic             q_fb,
  output logic             S,
  output logic             R,
  output logic             busy,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_e;

  // Channel index 0 carries the set request, index 1 the clear request.
  logic [1:0]       raw_in;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_dly_q, deb_dly_d;
  logic [DW-1:0]    deb_cnt_q [2];
  logic [DW-1:0]    deb_cnt_d [2];
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       req;
  logic [1:0]       kept;
  logic [1:0]       served;
  state_e           state_q, state_d;
  logic [PW-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  assign raw_in = {clr_in, set_in};

  // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    sync1_d   = raw_in;
    sync2_d   = sync1_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    for (int ch = 0; ch < 2; ch++) begin
      deb_cnt_d[ch] = '0;
      if (sync2_q[ch] != deb_q[ch]) begin
        if (deb_cnt_q[ch] == DEB_LAST) begin
          deb_d[ch] = sync2_q[ch];
        end else begin
          deb_cnt_d[ch] = deb_cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  assign req = deb_q & ~deb_dly_q;

  always_comb begin
    conflict_d = req[0] & req[1];
    kept       = req;
    if (conflict_d) begin
      case (PRIORITY)
        0:       kept = 2'b10;
        1:       kept = 2'b01;
        default: kept = 2'b00;
      endcase
    end
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_d && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  // A pending request is dropped without a pulse when Q already holds the requested value.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = '0;
    served      = 2'b00;
    case (state_q)
      IDLE: begin
        if (pend_q[1] && (!pend_q[0] || (PRIORITY != 1))) begin
          served[1] = 1'b1;
          if (q_fb) begin
            state_d = PULSE_R;
          end
        end else if (pend_q[0]) begin
          served[0] = 1'b1;
          if (!q_fb) begin
            state_d = PULSE_S;
          end
        end
      end
      PULSE_S, PULSE_R: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d = GAP;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pend_d = (pend_q | kept) & ~served;
    s_d    = (state_d == PULSE_S);
    r_d    = (state_d == PULSE_R);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      deb_dly_q      <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        deb_cnt_q[ch] <= '0;
      end
      pend_q         <= '0;
      state_q        <= IDLE;
      pulse_cnt_q    <= '0;
      s_q            <= 1'b0;
      r_q            <= 1'b0;
      busy_q         <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      deb_q          <= deb_d;
      deb_dly_q      <= deb_dly_d;
      for (int ch = 0; ch < 2; ch++) begin
        deb_cnt_q[ch] <= deb_cnt_d[ch];
      end
      pend_q         <= pend_d;
      state_q        <= state_d;
      pulse_cnt_q    <= pulse_cnt_d;
      s_q            <= s_d;
      r_q            <= r_d;
      busy_q         <= busy_d;
      conflict_q     <= conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign S            = s_q;
  assign R            = r_q;
  assign busy         = busy_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_sr_request_conditioner.sv
// Self-checking bench for sr_request_conditioner: table-driven scenarios, hand-written
// corner sequences and a randomized run compared against a behavioural model.
module tb_sr_request_conditioner;

  localparam int DEB = 4;
  localparam int PW  = 2;
  localparam int PRI = 0;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          set_in, clr_in, q_fb;
  logic          S, R, busy, conflict;
  logic [CW-1:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  sr_request_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PW),
    .PRIORITY       (PRI),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_in      (set_in),
    .clr_in      (clr_in),
    .q_fb        (q_fb),
    .S           (S),
    .R           (R),
    .busy        (busy),
    .conflict    (conflict),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: debounce as "last DEB synchronised samples all disagree",
  // pulse engine as a countdown of remaining busy cycles.
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_deb [2];
  bit m_debp [2];
  bit m_pend [2];
  bit hist [2][DEB];
  int hlen [2];
  int m_left;
  bit m_chan;
  bit m_conf;
  int m_cnt;
  bit modelCheck = 1'b0;

  int   cntS, cntR, cntConf, cntBusy, overlap, cyc, firstS, firstR;
  logic prevS, prevR;

  typedef struct {
    bit s;
    bit c;
    bit q;
    int hold;
    int expS;
    int expR;
    int expConf;
  } vec_t;

  vec_t vecs [9];

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0; m_debp[c] = 0; m_pend[c] = 0; hlen[c] = 0;
      for (int i = 0; i < DEB; i++) hist[c][i] = 0;
    end
    m_left = 0; m_chan = 0; m_conf = 0; m_cnt = 0;
  endtask

  task automatic modelStep(input bit si, input bit ci, input bit qf);
    bit req [2];
    bit kept [2];
    bit served [2];
    bit newDeb [2];
    bit conf;
    bit allDiff;
    int pick;
    for (int c = 0; c < 2; c++) begin
      req[c]    = m_deb[c] & ~m_debp[c];
      kept[c]   = req[c];
      served[c] = 0;
    end
    conf = req[0] & req[1];
    if (conf) begin
      kept[0] = (PRI == 1);
      kept[1] = (PRI == 0);
    end
    pick = -1;
    if (m_left == 0) begin
      if (m_pend[0] && m_pend[1]) pick = (PRI == 1) ? 0 : 1;
      else if (m_pend[0]) pick = 0;
      else if (m_pend[1]) pick = 1;
    end
    if (m_left > 0) m_left--;
    if (pick >= 0) begin
      served[pick] = 1;
      // a pulse is only sent when Q differs from the value the request asks for
      if (qf != (pick == 0)) begin
        m_left = PW + 1;
        m_chan = pick[0];
      end
    end
    for (int c = 0; c < 2; c++) begin
      m_pend[c] = (m_pend[c] | kept[c]) & ~served[c];
      for (int i = DEB - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = m_s2[c];
      if (hlen[c] < DEB) hlen[c]++;
      allDiff = (hlen[c] == DEB);
      for (int i = 0; i < DEB; i++) if (hist[c][i] == m_deb[c]) allDiff = 0;
      newDeb[c] = allDiff ? ~m_deb[c] : m_deb[c];
    end
    m_debp  = m_deb;
    m_deb   = newDeb;
    m_s2    = m_s1;
    m_s1[0] = si;
    m_s1[1] = ci;
    m_conf  = conf;
    if (conf && (m_cnt < (1 << CW) - 1)) m_cnt++;
  endtask

  function automatic logic [31:0] expVec();
    logic          eS, eR, eB;
    logic [CW-1:0] c;
    eS = (m_left > 1) && (m_chan == 1'b0);
    eR = (m_left > 1) && (m_chan == 1'b1);
    eB = (m_left > 0);
    c  = CW'(m_cnt);
    return 32'({eS, eR, eB, m_conf, c});
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit c, input bit q);
    set_in = s;
    clr_in = c;
    q_fb   = q;
  endtask

  task automatic clearCounts();
    cntS = 0; cntR = 0; cntConf = 0; cntBusy = 0; overlap = 0; cyc = 0;
    firstS = -1; firstR = -1;
    prevS = S; prevR = R;
  endtask

  // One clock: the model steps on the same edge as the DUT, outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    modelStep(set_in, clr_in, q_fb);
    #1;
    cyc++;
    if (S && !prevS) begin cntS++; if (firstS < 0) firstS = cyc; end
    if (R && !prevR) begin cntR++; if (firstR < 0) firstR = cyc; end
    if (conflict) cntConf++;
    if (busy) cntBusy++;
    if (S && R) overlap++;
    prevS = S;
    prevR = R;
    if (modelCheck) checkOutput("random_cycle", 32'({S, R, busy, conflict, conflict_cnt}), expVec());
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    clearCounts();
  endtask

  initial begin
    bit found;
    bit ns, nc, nq, lvl;
    int holdS, holdC, h;

    rst_n = 1'b0;
    applyStimulus(0, 0, 0);

    vecs[0] = '{1, 0, 0, 20, 1, 0, 0};
    vecs[1] = '{1, 0, 1, 20, 0, 0, 0};
    vecs[2] = '{0, 1, 1,  3, 0, 0, 0};
    vecs[3] = '{0, 1, 1,  4, 0, 1, 0};
    vecs[4] = '{0, 1, 0, 20, 0, 0, 0};
    vecs[5] = '{1, 1, 1, 20, 0, 1, 1};
    vecs[6] = '{1, 1, 0, 20, 0, 0, 1};
    vecs[7] = '{1, 0, 0,  3, 0, 0, 0};
    vecs[8] = '{1, 0, 0,  4, 1, 0, 0};

    doReset();
    checkOutput("reset_state", 32'({S, R, busy, conflict, conflict_cnt}), 32'd0);

    for (int i = 0; i < 9; i++) begin
      doReset();
      applyStimulus(vecs[i].s, vecs[i].c, vecs[i].q);
      repeat (vecs[i].hold) tick();
      applyStimulus(0, 0, vecs[i].q);
      repeat (25) tick();
      checkOutput($sformatf("vec%0d_s_pulses", i), cntS, vecs[i].expS);
      checkOutput($sformatf("vec%0d_r_pulses", i), cntR, vecs[i].expR);
      checkOutput($sformatf("vec%0d_conflicts", i), cntConf, vecs[i].expConf);
      checkOutput($sformatf("vec%0d_conflict_cnt", i), 32'(conflict_cnt), vecs[i].expConf);
      checkOutput($sformatf("vec%0d_busy_cycles", i), cntBusy, (vecs[i].expS + vecs[i].expR) * (PW + 1));
      checkOutput($sformatf("vec%0d_overlap", i), overlap, 0);
    end

    // Exact latency: first sampling edge is the first tick after driving set_in.
    doReset();
    applyStimulus(1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkOutput($sformatf("latency_k%0d", k), 32'({S, R, busy}),
                  32'({(k == 8 || k == 9), 1'b0, (k >= 8 && k <= 10)}));
    end

    // Asynchronous reset in the middle of an S pulse.
    doReset();
    applyStimulus(1, 1, 0);
    repeat (8) tick();
    applyStimulus(0, 0, 0);
    repeat (8) tick();
    checkOutput("t1_cnt_before_reset", 32'(conflict_cnt), 32'd1);
    applyStimulus(1, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (S) found = 1'b1;
    end
    checkOutput("t1_reached_pulse", 32'(found), 32'd1);
    #2;
    rst_n  = 1'b0;
    set_in = 1'b0;
    #1;
    checkOutput("t1_async_reset", 32'({S, R, busy, conflict, conflict_cnt}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    clearCounts();
    repeat (20) tick();
    checkOutput("t1_no_pulse_after", cntS + cntR + cntBusy, 0);

    // Ordering with a model flip-flop closing the Q loop.
    doReset();
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(1, 1, 0);
    for (int k = 0; k < 30; k++) begin
      tick();
      q_fb = S ? 1'b1 : (R ? 1'b0 : q_fb);
    end
    checkOutput("t5_s_pulses", cntS, 1);
    checkOutput("t5_r_pulses", cntR, 1);
    checkOutput("t5_conflicts", cntConf, 0);
    checkOutput("t5_overlap", overlap, 0);
    checkOutput("t5_s_to_r_spacing", firstR - firstS, PW + 2);

    // Saturation of the conflict counter.
    doReset();
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1, 1, 0);
      repeat (8) tick();
      applyStimulus(0, 0, 0);
      repeat (8) tick();
    end
    checkOutput("t6_conflict_pulses", cntConf, 300);
    checkOutput("t6_cnt_saturated", 32'(conflict_cnt), 32'd255);
    checkOutput("t6_never_busy", cntBusy, 0);

    // Randomized levels and hold times against the model.
    doReset();
    modelCheck = 1'b1;
    holdS = 0;
    holdC = 0;
    ns = 0; nc = 0; nq = 0;
    for (int n = 0; n < 4000; n++) begin
      if (holdS <= 0 && holdC <= 0 && $urandom_range(0, 3) == 0) begin
        lvl = 1'($urandom_range(0, 1));
        h   = int'($urandom_range(1, 10));
        ns = lvl; nc = lvl; holdS = h; holdC = h;
      end else begin
        if (holdS <= 0) begin ns = 1'($urandom_range(0, 1)); holdS = int'($urandom_range(1, 10)); end
        if (holdC <= 0) begin nc = 1'($urandom_range(0, 1)); holdC = int'($urandom_range(1, 10)); end
      end
      if ($urandom_range(0, 15) == 0) nq = ~nq;
      applyStimulus(ns, nc, nq);
      tick();
      holdS--;
      holdC--;
    end
    modelCheck = 1'b0;
    checkOutput("random_no_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
